// File: rtl/mem_stage_ctrl.sv
// Memory stage of the 16-bit pipeline: data-memory handshake, upstream stall and M/W register.
// Optional watchdog on outstanding accesses is compiled in with `define MEM_TIMEOUT_EN.
module mem_stage_ctrl #(
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memRead_IN,
  input  logic              memWrite_IN,
  input  logic [DATA_W-1:0] addr_IN,
  input  logic [DATA_W-1:0] memData_IN,
  input  logic [DATA_W-1:0] writeRegDataExecute_IN,
  input  logic              writeEn_IN,
  input  logic [2:0]        writeRegSel_IN,
  input  logic              halt_IN,
  input  logic              err_IN,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_OUT,
  output logic              wbEn_OUT,
  output logic [2:0]        wbSel_OUT,
  output logic [DATA_W-1:0] wbData_OUT,
  output logic              halt_OUT,
  output logic              err_OUT
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t state;

  logic memop;
  logic misaligned;
  logic access;
  logic is_load;
  logic timeout_c;
  logic stall_c;

  // Instruction decode; read+write together is treated as a write.
  assign memop      = (memRead_IN | memWrite_IN) & ~halt_IN & ~err_IN;
  assign misaligned = memop & addr_IN[0];
  assign access     = memop & ~misaligned;
  assign is_load    = access & ~memWrite_IN;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] to_cnt;

  // Counts cycles spent in REQ/WAIT; held at zero while idle so it restarts on REQ entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if (state == S_IDLE) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + CNT_W'(1);
    end
  end

  assign timeout_c = (state != S_IDLE) && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_c = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  // Stall is released in the completing cycle so M/W captures the result on that edge.
  always_comb begin
    stall_c = 1'b0;
    case (state)
      S_IDLE:  stall_c = access;
      S_REQ:   stall_c = ~timeout_c;
      S_WAIT:  stall_c = ~(mem_done | timeout_c);
      default: stall_c = 1'b0;
    endcase
  end

  assign stall_OUT = stall_c;
  assign mem_req   = (state == S_REQ);
  assign mem_wr    = (state == S_REQ) & memWrite_IN;
  assign mem_addr  = addr_IN;
  assign mem_wdata = memData_IN;

  // Access sequencing; mem_done outside WAIT is ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (access) state <= S_REQ;
        end
        S_REQ: begin
          if (timeout_c)      state <= S_IDLE;
          else if (mem_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_done | timeout_c) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // M/W register: bubble while stalled, otherwise the completing instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbEn_OUT   <= 1'b0;
      wbSel_OUT  <= '0;
      wbData_OUT <= '0;
      halt_OUT   <= 1'b0;
      err_OUT    <= 1'b0;
    end else if (stall_c) begin
      wbEn_OUT <= 1'b0;
      halt_OUT <= 1'b0;
      err_OUT  <= 1'b0;
    end else if (timeout_c) begin
      wbEn_OUT  <= 1'b0;
      wbSel_OUT <= writeRegSel_IN;
      halt_OUT  <= halt_IN;
      err_OUT   <= 1'b1;
    end else begin
      wbEn_OUT   <= writeEn_IN & ~misaligned & ~err_IN;
      wbSel_OUT  <= writeRegSel_IN;
      wbData_OUT <= is_load ? mem_rdata : writeRegDataExecute_IN;
      halt_OUT   <= halt_IN;
      err_OUT    <= err_IN | misaligned;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: expected M/W results queued at issue, compared at completion.
// Watchdog steps are included when MEM_TIMEOUT_EN is defined.
module tb_mem_stage_ctrl;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 64;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        memRead_IN, memWrite_IN, writeEn_IN, halt_IN, err_IN;
  logic [15:0] addr_IN, memData_IN, writeRegDataExecute_IN;
  logic [2:0]  writeRegSel_IN;
  logic        mem_req, mem_wr, mem_ready, mem_done;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall_OUT, wbEn_OUT, halt_OUT, err_OUT;
  logic [2:0]  wbSel_OUT;
  logic [15:0] wbData_OUT;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        en;
    logic [2:0]  sel;
    logic [15:0] data;
    logic        halt;
    logic        err;
    bit          chk_data;
  } mw_t;

  mw_t sb[$];

  mem_stage_ctrl #(.DATA_W(16), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .memRead_IN(memRead_IN), .memWrite_IN(memWrite_IN),
    .addr_IN(addr_IN), .memData_IN(memData_IN),
    .writeRegDataExecute_IN(writeRegDataExecute_IN),
    .writeEn_IN(writeEn_IN), .writeRegSel_IN(writeRegSel_IN),
    .halt_IN(halt_IN), .err_IN(err_IN),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .stall_OUT(stall_OUT), .wbEn_OUT(wbEn_OUT), .wbSel_OUT(wbSel_OUT),
    .wbData_OUT(wbData_OUT), .halt_OUT(halt_OUT), .err_OUT(err_OUT)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [15:0] exe, input logic we,
                       input logic [2:0] sel, input logic hlt, input logic er);
    memRead_IN = rd; memWrite_IN = wr; addr_IN = addr; memData_IN = wdata;
    writeRegDataExecute_IN = exe; writeEn_IN = we; writeRegSel_IN = sel;
    halt_IN = hlt; err_IN = er;
  endtask

  task automatic push(input logic en, input logic [2:0] sel, input logic [15:0] data,
                      input logic hlt, input logic er, input bit cd);
    mw_t e;
    e.en = en; e.sel = sel; e.data = data; e.halt = hlt; e.err = er; e.chk_data = cd;
    sb.push_back(e);
  endtask

  // Pops the oldest expected completion and compares it against the M/W outputs.
  task automatic check_mw(input string tag);
    mw_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty observed=none expected=entry", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_wbEn"}, 32'(wbEn_OUT), 32'(e.en));
    chk({tag, "_wbSel"}, 32'(wbSel_OUT), 32'(e.sel));
    if (e.chk_data) chk({tag, "_wbData"}, 32'(wbData_OUT), 32'(e.data));
    chk({tag, "_halt"}, 32'(halt_OUT), 32'(e.halt));
    chk({tag, "_err"}, 32'(err_OUT), 32'(e.err));
  endtask

  task automatic check_bubble(input string tag, input logic [2:0] sel, input logic [15:0] data);
    chk({tag, "_wbEn"}, 32'(wbEn_OUT), 32'd0);
    chk({tag, "_halt"}, 32'(halt_OUT), 32'd0);
    chk({tag, "_err"}, 32'(err_OUT), 32'd0);
    chk({tag, "_wbSel"}, 32'(wbSel_OUT), 32'(sel));
    chk({tag, "_wbData"}, 32'(wbData_OUT), 32'(data));
  endtask

  initial begin
    rst = 1'b0;
    mem_ready = 1'b0; mem_done = 1'b0; mem_rdata = 16'hDEAD;
    drive(0, 0, 16'h0, 16'h0, 16'h0, 0, 3'd0, 0, 0);
    tick(); tick();
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_stall", 32'(stall_OUT), 32'd0);
    chk("rst_wbEn", 32'(wbEn_OUT), 32'd0);
    chk("rst_wbData", 32'(wbData_OUT), 32'd0);

    // Start a load, reach WAIT, then reset mid-access.
    rst = 1'b1;
    drive(1, 0, 16'h0040, 16'h0, 16'h0, 1, 3'd1, 0, 0);
    mem_ready = 1'b1;
    #1 chk("rw_idle_stall", 32'(stall_OUT), 32'd1);
    tick();
    chk("rw_req", 32'(mem_req), 32'd1);
    tick();
    mem_ready = 1'b0;
    #1 chk("rw_wait_req", 32'(mem_req), 32'd0);
    chk("rw_wait_stall", 32'(stall_OUT), 32'd1);
    rst = 1'b0;
    drive(0, 0, 16'h0, 16'h0, 16'h0, 0, 3'd0, 0, 0);
    #1 chk("rw_rst_stall", 32'(stall_OUT), 32'd0);
    chk("rw_rst_req", 32'(mem_req), 32'd0);
    check_bubble("rw_rst", 3'd0, 16'h0);
    tick();
    rst = 1'b1;
    tick();
    // Stray done in IDLE.
    mem_done = 1'b1;
    #1 chk("stray_stall", 32'(stall_OUT), 32'd0);
    chk("stray_req", 32'(mem_req), 32'd0);
    push(0, 3'd0, 16'h0, 0, 0, 1);
    tick();
    mem_done = 1'b0;
    check_mw("stray");

    // ALU pass-through.
    drive(0, 0, 16'h0008, 16'h0, 16'h1234, 1, 3'd3, 0, 0);
    push(1, 3'd3, 16'h1234, 0, 0, 1);
    #1 chk("alu_stall", 32'(stall_OUT), 32'd0);
    chk("alu_req", 32'(mem_req), 32'd0);
    tick();
    check_mw("alu");

    // Load with ready at once and done two cycles after acceptance.
    drive(1, 0, 16'h0010, 16'h0, 16'h7777, 1, 3'd5, 0, 0);
    push(1, 3'd5, 16'hBEEF, 0, 0, 1);
    mem_ready = 1'b1;
    #1 chk("ld_c0_stall", 32'(stall_OUT), 32'd1);
    chk("ld_c0_req", 32'(mem_req), 32'd0);
    tick();
    check_bubble("ld_b0", 3'd3, 16'h1234);
    #1 chk("ld_c1_stall", 32'(stall_OUT), 32'd1);
    chk("ld_c1_req", 32'(mem_req), 32'd1);
    chk("ld_c1_wr", 32'(mem_wr), 32'd0);
    chk("ld_c1_addr", 32'(mem_addr), 32'h0010);
    tick();
    check_bubble("ld_b1", 3'd3, 16'h1234);
    mem_ready = 1'b0;
    #1 chk("ld_c2_stall", 32'(stall_OUT), 32'd1);
    chk("ld_c2_req", 32'(mem_req), 32'd0);
    tick();
    check_bubble("ld_b2", 3'd3, 16'h1234);
    mem_done = 1'b1; mem_rdata = 16'hBEEF;
    #1 chk("ld_c3_stall", 32'(stall_OUT), 32'd0);
    tick();
    mem_done = 1'b0; mem_rdata = 16'hDEAD;
    check_mw("ld");

    // Store with memory not ready for two cycles.
    drive(0, 1, 16'h0020, 16'hA5A5, 16'h5555, 0, 3'd2, 0, 0);
    push(0, 3'd2, 16'h5555, 0, 0, 1);
    #1 chk("st_c0_stall", 32'(stall_OUT), 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) mem_ready = 1'b1;
      #1 chk("st_req", 32'(mem_req), 32'd1);
      chk("st_wr", 32'(mem_wr), 32'd1);
      chk("st_addr", 32'(mem_addr), 32'h0020);
      chk("st_wdata", 32'(mem_wdata), 32'hA5A5);
      chk("st_stall", 32'(stall_OUT), 32'd1);
      tick();
    end
    mem_ready = 1'b0; mem_done = 1'b1;
    #1 chk("st_done_stall", 32'(stall_OUT), 32'd0);
    chk("st_done_req", 32'(mem_req), 32'd0);
    tick();
    mem_done = 1'b0;
    check_mw("st");

    // Misaligned load.
    drive(1, 0, 16'h0011, 16'h0, 16'h9999, 1, 3'd4, 0, 0);
    push(0, 3'd4, 16'h0, 0, 1, 0);
    #1 chk("mis_stall", 32'(stall_OUT), 32'd0);
    chk("mis_req", 32'(mem_req), 32'd0);
    tick();
    check_mw("mis");
    drive(0, 0, 16'h0, 16'h0, 16'h0, 0, 3'd0, 0, 0);
    #1 chk("mis_after_req", 32'(mem_req), 32'd0);

    // Halt with a load encoded: no access, passes through.
    drive(1, 0, 16'h0030, 16'h0, 16'h4242, 1, 3'd6, 1, 0);
    push(1, 3'd6, 16'h4242, 1, 0, 1);
    #1 chk("hlt_stall", 32'(stall_OUT), 32'd0);
    tick();
    chk("hlt_req", 32'(mem_req), 32'd0);
    check_mw("hlt");

    // Upstream error with a store: no access, writeback suppressed.
    drive(0, 1, 16'h0031, 16'h0, 16'h1111, 1, 3'd7, 0, 1);
    push(0, 3'd7, 16'h1111, 0, 1, 1);
    #1 chk("err_stall", 32'(stall_OUT), 32'd0);
    tick();
    chk("err_req", 32'(mem_req), 32'd0);
    check_mw("err");

`ifdef MEM_TIMEOUT_EN
    // Load whose done never arrives: watchdog completes it with an error.
    drive(1, 0, 16'h0050, 16'h0, 16'h3333, 1, 3'd1, 0, 0);
    push(0, 3'd1, 16'h1111, 0, 1, 1);
    mem_ready = 1'b1;
    #1 chk("to_c0_stall", 32'(stall_OUT), 32'd1);
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1 chk("to_stall", 32'(stall_OUT), (i == 7) ? 32'd0 : 32'd1);
      tick();
    end
    check_mw("to");
    drive(0, 0, 16'h0, 16'h0, 16'h0, 0, 3'd0, 0, 0);
    #1 chk("to_idle_stall", 32'(stall_OUT), 32'd0);
    chk("to_idle_req", 32'(mem_req), 32'd0);
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
Memory stage of the 5-stage 16-bit pipeline. It sits between the X/M pipeline registers and the M/W pipeline registers.
- Consumes the X/M outputs (address, store data, control, writeback info).
- Runs the handshake to the multi-cycle data memory.
- Stalls the upstream stages while an access is outstanding.
- Drives the registered M/W outputs consumed by writeback and forwarding.

Parameters:
- DATA_W, 16, data and address width.
- TIMEOUT_CYCLES, 64, watchdog limit in cycles. Used only when MEM_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock. Everything is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- memRead_IN  in  1  load in the X/M stage.
- memWrite_IN  in  1  store in the X/M stage.
- addr_IN  in  DATA_W  ALU output, used as the memory address.
- memData_IN  in  DATA_W  store data.
- writeRegDataExecute_IN  in  DATA_W  non-load writeback data.
- writeEn_IN  in  1  register writeback enable.
- writeRegSel_IN  in  3  destination register.
- halt_IN  in  1  halt instruction.
- err_IN  in  1  upstream error.
- mem_req  out  1  memory request.
- mem_wr  out  1  1 = write, 0 = read.
- mem_addr  out  DATA_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ready  in  1  memory can accept a request this cycle.
- mem_done  in  1  access complete. For reads, mem_rdata is valid in this cycle.
- mem_rdata  in  DATA_W  read data.
- stall_OUT  out  1  holds the X/M register and everything upstream.
- wbEn_OUT  out  1  registered M/W writeback enable.
- wbSel_OUT  out  3  registered M/W destination register.
- wbData_OUT  out  DATA_W  registered M/W writeback data.
- halt_OUT  out  1  registered M/W halt.
- err_OUT  out  1  registered M/W error.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - mem_req=0, stall_OUT=0.
  - All registered M/W outputs = 0.
- Input decoding:
  - memop = (memRead_IN | memWrite_IN) & ~halt_IN & ~err_IN.
  - misaligned = memop & addr_IN[0].
  - memRead_IN=memWrite_IN=1 together is treated as a write.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - memop & ~misaligned → go to REQ, stall_OUT=1.
  - Otherwise the instruction passes through in one cycle, stall_OUT=0.
- REQ:
  - mem_req=1.
  - mem_wr = memWrite_IN.
  - mem_addr = addr_IN, mem_wdata = memData_IN.
  - These values are stable because X/M is held.
  - mem_ready=1 → go to WAIT. Otherwise stay in REQ.
  - stall_OUT=1.
- WAIT:
  - mem_req=0.
  - mem_done=1 → go to IDLE, stall_OUT=0 in this same cycle, and the M/W register captures the result.
  - mem_done=0 → stay in WAIT, stall_OUT=1.
- Minimum load/store latency is 3 cycles: IDLE, REQ with ready, WAIT with done.
- mem_done is ignored in IDLE and REQ (covers a stray done after reset).
- M/W capture, on every edge:
  - stall_OUT=0 → capture the completing instruction:
    - wbEn = writeEn_IN & ~misaligned & ~err_IN.
    - wbSel = writeRegSel_IN.
    - wbData = mem_rdata for a load, else writeRegDataExecute_IN.
    - halt = halt_IN.
    - err = err_IN | misaligned.
  - stall_OUT=1 → capture a bubble: wbEn=0, halt=0, err=0, wbSel and wbData unchanged.
- Misaligned access:
  - No memory request is issued.
  - Completes in one cycle with err_OUT=1 and wbEn_OUT=0.
- Halt or error in M: no memory access; propagates unchanged.
- Reset in REQ or WAIT: immediate return to IDLE. The outstanding request is abandoned; the memory is reset by the same rst.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES)+1 clears on entry to REQ and counts each cycle in REQ or WAIT.
  - On reaching TIMEOUT_CYCLES without completion, the FSM goes to IDLE.
  - The access completes as if done, with err_OUT=1, wbEn_OUT=0 and wbData unchanged.
  - The counter resets to 0 asynchronously.
- Undefined: no counter; the FSM waits indefinitely for mem_ready / mem_done.

Test Plan:
- Reset held mid-WAIT, then released → mem_req=0, stall_OUT=0, all M/W outputs 0. A mem_done pulse arriving in IDLE is ignored.
- ALU op, writeEn=1, sel=3, data=0x1234, no memop → next edge wbEn_OUT=1, wbSel_OUT=3, wbData_OUT=0x1234, stall_OUT never asserted.
- Load addr=0x0010, mem_ready=1, mem_done 2 cycles later with rdata=0xBEEF, sel=5:
  - stall_OUT high for 3 cycles.
  - Bubbles on M/W meanwhile.
  - Then wbEn_OUT=1, wbSel_OUT=5, wbData_OUT=0xBEEF.
- Store addr=0x0020, data=0xA5A5, mem_ready low for 2 cycles:
  - mem_req held with mem_wr=1, addr=0x0020, wdata=0xA5A5 until ready.
  - Completes on done with wbEn_OUT=0.
- Load addr=0x0011 → no mem_req; next edge err_OUT=1, wbEn_OUT=0, no stall.
- With MEM_TIMEOUT_EN, TIMEOUT_CYCLES=8, load with mem_done never asserted → after 8 cycles in REQ/WAIT: IDLE, err_OUT=1, stall_OUT=0.
